// File: rtl/regs_file_scoreboard.sv
// regs_file_scoreboard: multi-port integer register file with same-cycle
// write-to-read bypass and a per-register pending-write counter.
// Decode reads operands and hazard status here, issue marks destinations
// pending, and writeback commits results and retires the pending marks.
module regs_file_scoreboard #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter int PW       = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREAD*AW-1:0] regNum,
  output logic [NREAD*DW-1:0] regReadData,
  output logic [NREAD-1:0]    regBusy,
  input  logic                regsWriteEnable,
  input  logic [AW-1:0]       regWriteNum,
  input  logic [DW-1:0]       regWriteData,
  input  logic                issueEnable,
  input  logic [AW-1:0]       issueNum,
  output logic                issueStall
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [PW-1:0] CNT_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] CNT_ONE  = PW'(1'b1);
  localparam logic [PW-1:0] CNT_MAX  = {PW{1'b1}};
  localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};

  // Packed storage so whole-array reset and per-entry updates stay simple.
  logic [DEPTH-1:0][DW-1:0] regs_r;
  logic [DEPTH-1:0][PW-1:0] cnt_r;

  logic             wr_valid_s;
  logic             issue_valid_s;
  logic             issue_retire_s;
  logic             stall_s;
  logic             inc_s;
  logic [DEPTH-1:0] inc_vec_s;
  logic [DEPTH-1:0] dec_vec_s;
  logic [AW-1:0]    rd_idx_s;
  logic             rd_dec_s;

  // Qualify writes and issues; an issue is refused when its counter is full
  // and no writeback retires one of its pending writes this cycle.
  always_comb begin
    wr_valid_s     = regsWriteEnable & ~(ZERO_REG & (regWriteNum == REG_ZERO));
    issue_valid_s  = issueEnable & ~(ZERO_REG & (issueNum == REG_ZERO));
    issue_retire_s = regsWriteEnable & (regWriteNum == issueNum) &
                     (cnt_r[issueNum] != CNT_ZERO);
    stall_s        = issue_valid_s & (cnt_r[issueNum] == CNT_MAX) & ~issue_retire_s;
    inc_s          = issue_valid_s & ~stall_s;
  end

  assign issueStall = stall_s;

  // Per-register increment/decrement requests for the pending counters.
  always_comb begin
    inc_vec_s = {DEPTH{1'b0}};
    dec_vec_s = {DEPTH{1'b0}};
    for (int r = 0; r < DEPTH; r++) begin
      inc_vec_s[r] = inc_s & (issueNum == AW'(r));
      dec_vec_s[r] = regsWriteEnable & (regWriteNum == AW'(r)) & (cnt_r[r] != CNT_ZERO);
    end
  end

  // Read ports: hard-wired zero, then writeback bypass, then the array.
  // Busy already discounts a write retiring this cycle so it agrees with
  // the bypassed data.
  always_comb begin
    regReadData = {(NREAD*DW){1'b0}};
    regBusy     = {NREAD{1'b0}};
    rd_idx_s    = REG_ZERO;
    rd_dec_s    = 1'b0;
    for (int k = 0; k < NREAD; k++) begin
      rd_idx_s = regNum[k*AW +: AW];
      rd_dec_s = regsWriteEnable & (regWriteNum == rd_idx_s) &
                 (cnt_r[rd_idx_s] != CNT_ZERO);
      if (ZERO_REG && (rd_idx_s == REG_ZERO)) begin
        regReadData[k*DW +: DW] = {DW{1'b0}};
        regBusy[k]              = 1'b0;
      end else begin
        if (regsWriteEnable && (regWriteNum == rd_idx_s)) begin
          regReadData[k*DW +: DW] = regWriteData;
        end else begin
          regReadData[k*DW +: DW] = regs_r[rd_idx_s];
        end
        regBusy[k] = ((cnt_r[rd_idx_s] - PW'(rd_dec_s)) != CNT_ZERO);
      end
    end
  end

  // Data array: cleared by reset, otherwise commits the writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_r <= {(DEPTH*DW){1'b0}};
    end else if (wr_valid_s) begin
      regs_r[regWriteNum] <= regWriteData;
    end
  end

  // Pending counters: issue adds a producer, writeback retires one; both in
  // the same cycle hand the slot over and leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {(DEPTH*PW){1'b0}};
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (inc_vec_s[r] && !dec_vec_s[r]) begin
          cnt_r[r] <= cnt_r[r] + CNT_ONE;
        end else if (dec_vec_s[r] && !inc_vec_s[r]) begin
          cnt_r[r] <= cnt_r[r] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_regs_file_scoreboard.sv
// Directed bench for regs_file_scoreboard with four read ports: a table of
// per-cycle vectors, then hand sequences for issue/write overlap and a sweep.
module tb_regs_file_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic             clk;
  logic             reset;
  logic [NR*AW-1:0] regNum;
  logic [NR*DW-1:0] regReadData;
  logic [NR-1:0]    regBusy;
  logic             regsWriteEnable;
  logic [AW-1:0]    regWriteNum;
  logic [DW-1:0]    regWriteData;
  logic             issueEnable;
  logic [AW-1:0]    issueNum;
  logic             issueStall;

  int errors = 0;
  int checks = 0;

  regs_file_scoreboard #(.DW(DW), .AW(AW), .NREAD(NR), .PW(2), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .regNum(regNum), .regReadData(regReadData),
    .regBusy(regBusy), .regsWriteEnable(regsWriteEnable), .regWriteNum(regWriteNum),
    .regWriteData(regWriteData), .issueEnable(issueEnable), .issueNum(issueNum),
    .issueStall(issueStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          we;
    logic [AW-1:0] wn;
    logic [DW-1:0] wd;
    logic          ie;
    logic [AW-1:0] in;
    logic [AW-1:0] rn [NR];
    logic [DW-1:0] ed [NR];
    logic [NR-1:0] eb;
    logic          es;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic we, input logic [AW-1:0] wn, input logic [DW-1:0] wd,
    input logic ie, input logic [AW-1:0] in,
    input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] r3,
    input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] d3,
    input logic [NR-1:0] eb, input logic es);
    vec_t v;
    v.rst = rst; v.we = we; v.wn = wn; v.wd = wd; v.ie = ie; v.in = in;
    v.rn[0] = r0; v.rn[1] = r1; v.rn[2] = r2; v.rn[3] = r3;
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2; v.ed[3] = d3;
    v.eb = eb; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset           = v.rst;
    regsWriteEnable = v.we;
    regWriteNum     = v.wn;
    regWriteData    = v.wd;
    issueEnable     = v.ie;
    issueNum        = v.in;
    regNum          = {v.rn[3], v.rn[2], v.rn[1], v.rn[0]};
  endtask

  // Drive before the negedge, compare on it, then let the posedge commit.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    for (int k = 0; k < NR; k++)
      chk($sformatf("%s data%0d", tag, k), regReadData[k*DW +: DW], v.ed[k]);
    chk($sformatf("%s busy", tag), {28'd0, regBusy}, {28'd0, v.eb});
    chk($sformatf("%s stall", tag), {31'd0, issueStall}, {31'd0, v.es});
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] BEEF = 32'hDEAD_BEEF;

  initial begin
    vec_t idle;
    // Reset state reads, then bypass and array reads of x5.
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0, 5'd5,5'd31,5'd5,5'd31, 32'h0,32'h0,32'h0,32'h0, 4'b0000,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd5,BEEF,1'b0,5'd0,  5'd5,5'd31,5'd0,5'd4,  BEEF,32'h0,32'h0,32'h0, 4'b0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0, 5'd5,5'd5,5'd31,5'd0,  BEEF,BEEF,32'h0,32'h0,   4'b0000,1'b0));
    // x0 ignores writes and issues.
    vecs.push_back(mk(1'b0,1'b1,5'd0,32'h1234_5678,1'b0,5'd0, 5'd0,5'd5,5'd0,5'd0, 32'h0,BEEF,32'h0,32'h0, 4'b0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0, 5'd0,5'd0,5'd0,5'd5, 32'h0,32'h0,32'h0,BEEF, 4'b0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b1,5'd0, 5'd0,5'd0,5'd0,5'd0, 32'h0,32'h0,32'h0,32'h0, 4'b0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0, 5'd0,5'd0,5'd0,5'd0, 32'h0,32'h0,32'h0,32'h0, 4'b0000,1'b0));
    // Issue x7 until saturated (count 3), fourth issue stalls.
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b1,5'd7, 5'd7,5'd7,5'd5,5'd0, 32'h0,32'h0,BEEF,32'h0, 4'b0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b1,5'd7, 5'd7,5'd7,5'd5,5'd0, 32'h0,32'h0,BEEF,32'h0, 4'b0011,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b1,5'd7, 5'd7,5'd7,5'd5,5'd0, 32'h0,32'h0,BEEF,32'h0, 4'b0011,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b1,5'd7, 5'd7,5'd7,5'd5,5'd0, 32'h0,32'h0,BEEF,32'h0, 4'b0011,1'b1));
    // Retire and issue together: no stall, count stays 3.
    vecs.push_back(mk(1'b0,1'b1,5'd7,32'hA5,1'b1,5'd7, 5'd7,5'd7,5'd5,5'd0, 32'hA5,32'hA5,BEEF,32'h0, 4'b0011,1'b0));
    // Three retiring writes; busy drops in the cycle of the last one.
    vecs.push_back(mk(1'b0,1'b1,5'd7,32'h1,1'b0,5'd0, 5'd7,5'd0,5'd5,5'd7, 32'h1,32'h0,BEEF,32'h1, 4'b1001,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd7,32'h2,1'b0,5'd0, 5'd7,5'd0,5'd5,5'd7, 32'h2,32'h0,BEEF,32'h2, 4'b1001,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd7,32'h3,1'b0,5'd0, 5'd7,5'd0,5'd5,5'd7, 32'h3,32'h0,BEEF,32'h3, 4'b0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0, 5'd7,5'd0,5'd5,5'd7, 32'h3,32'h0,BEEF,32'h3, 4'b0000,1'b0));
    // Direct write with nothing pending leaves the counter at zero.
    vecs.push_back(mk(1'b0,1'b1,5'd7,32'h4,1'b0,5'd0, 5'd7,5'd0,5'd5,5'd7, 32'h4,32'h0,BEEF,32'h4, 4'b0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0, 5'd7,5'd0,5'd5,5'd7, 32'h4,32'h0,BEEF,32'h4, 4'b0000,1'b0));
    // Issue x9 and x10, then reset while writing x9: everything cleared.
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b1,5'd9,  5'd9,5'd10,5'd5,5'd7, 32'h0,32'h0,BEEF,32'h4, 4'b0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b1,5'd10, 5'd9,5'd10,5'd5,5'd7, 32'h0,32'h0,BEEF,32'h4, 4'b0001,1'b0));
    vecs.push_back(mk(1'b1,1'b1,5'd9,32'h55,1'b0,5'd0, 5'd9,5'd10,5'd5,5'd7, 32'h55,32'h0,BEEF,32'h4, 4'b0010,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,  5'd9,5'd10,5'd5,5'd7, 32'h0,32'h0,32'h0,32'h0, 4'b0000,1'b0));
    // Four ports on the same register while it is written.
    vecs.push_back(mk(1'b0,1'b1,5'd4,32'h1111,1'b0,5'd0, 5'd4,5'd3,5'd3,5'd3, 32'h1111,32'h0,32'h0,32'h0, 4'b0000,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd3,32'h0F0F,1'b0,5'd0, 5'd3,5'd3,5'd3,5'd4, 32'h0F0F,32'h0F0F,32'h0F0F,32'h1111, 4'b0000,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,    5'd3,5'd3,5'd3,5'd3, 32'h0F0F,32'h0F0F,32'h0F0F,32'h0F0F, 4'b0000,1'b0));

    idle = mk(1'b1,1'b0,5'd0,32'h0,1'b0,5'd0, 5'd0,5'd0,5'd0,5'd0, 32'h0,32'h0,32'h0,32'h0, 4'b0000,1'b0);
    drive(idle);
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Issue and write x12 together with nothing pending: counts up to 1.
    run_vec(mk(1'b0,1'b1,5'd12,32'h77,1'b1,5'd12, 5'd12,5'd0,5'd0,5'd0, 32'h77,32'h0,32'h0,32'h0, 4'b0000,1'b0), "ovl0");
    run_vec(mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,     5'd12,5'd0,5'd0,5'd0, 32'h77,32'h0,32'h0,32'h0, 4'b0001,1'b0), "ovl1");
    run_vec(mk(1'b0,1'b1,5'd12,32'h88,1'b0,5'd0,  5'd12,5'd0,5'd0,5'd0, 32'h88,32'h0,32'h0,32'h0, 4'b0000,1'b0), "ovl2");
    run_vec(mk(1'b0,1'b0,5'd0,32'h0,1'b0,5'd0,     5'd12,5'd0,5'd0,5'd0, 32'h88,32'h0,32'h0,32'h0, 4'b0000,1'b0), "ovl3");

    // Sweep: write every register with a distinct pattern, read all back.
    for (int r = 0; r < 32; r++) begin
      reset = 1'b0; issueEnable = 1'b0; issueNum = 5'd0;
      regsWriteEnable = 1'b1; regWriteNum = 5'(r); regWriteData = 32'hA000_0000 | 32'(r);
      @(posedge clk);
      #1;
    end
    regsWriteEnable = 1'b0;
    for (int r = 0; r < 32; r++) begin
      regNum = {5'd0, 5'd0, 5'd0, 5'(r)};
      @(negedge clk);
      chk($sformatf("sweep x%0d", r), regReadData[DW-1:0],
          (r == 0) ? 32'h0 : (32'hA000_0000 | 32'(r)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
